// File: rtl/alu_share_arb.sv
// alu_share_arb: shares one external combinational 32-bit ALU between two
// requesters (port 0 = pipeline EX stage, port 1 = coprocessor).
// Flow: IDLE (arbitrate, latch operands) -> EXEC (drive ALU, wait LAT_EXTRA
// extra cycles) -> RESP (hold result until the owner consumes it) -> IDLE.
// Build option: define ALU_ARB_RR_EN for round-robin arbitration on ties;
// otherwise port 0 has fixed priority and port 1 may starve.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a request; ready shown to the granted port only
// EXEC  | alu_* driven from latched operands, counter runs 0..LAT_EXTRA
// RESP  | result held, rsp<owner>_valid high until rsp<owner>_ready
module alu_share_arb #(
  parameter int LAT_EXTRA = 0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req0_valid,
  input  logic [3:0]  i_req0_op,
  input  logic [31:0] i_req0_a,
  input  logic [31:0] i_req0_b,
  input  logic [4:0]  i_req0_shamt,
  output logic        o_req0_ready,
  input  logic        i_req1_valid,
  input  logic [3:0]  i_req1_op,
  input  logic [31:0] i_req1_a,
  input  logic [31:0] i_req1_b,
  input  logic [4:0]  i_req1_shamt,
  output logic        o_req1_ready,
  output logic        o_rsp0_valid,
  output logic        o_rsp1_valid,
  input  logic        i_rsp0_ready,
  input  logic        i_rsp1_ready,
  output logic [31:0] o_rsp_data,
  output logic        o_rsp_ovf,
  output logic [31:0] o_alu_a,
  output logic [31:0] o_alu_b,
  output logic [4:0]  o_alu_shamt,
  output logic [3:0]  o_alu_op,
  input  logic [31:0] i_alu_o,
  input  logic        i_alu_ovf
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] LAT_CNT = 4'(LAT_EXTRA);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_owner;
  logic        r_rsp0_valid;
  logic        r_rsp1_valid;
  logic [31:0] r_rsp_data;
  logic        r_rsp_ovf;
  logic [31:0] r_alu_a;
  logic [31:0] r_alu_b;
  logic [4:0]  r_alu_shamt;
  logic [3:0]  r_alu_op;

  logic w_grant0;
  logic w_grant1;
  logic w_accept;
  logic w_rsp_hs;

`ifdef ALU_ARB_RR_EN
  // Last-granted port; reset to 1 so port 0 wins the first tie.
  logic r_last;

  // Round-robin: on a tie, port 1 wins only if port 0 was granted last.
  always_comb begin
    w_grant1 = i_req1_valid && (!i_req0_valid || !r_last);
    w_grant0 = i_req0_valid && !w_grant1;
  end

  // Pointer tracks the winner of every accepted request.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      r_last <= 1'b1;
    else if (w_accept)
      r_last <= w_grant1;
  end
`else
  // Fixed priority: port 0 always wins a tie.
  always_comb begin
    w_grant0 = i_req0_valid;
    w_grant1 = i_req1_valid && !i_req0_valid;
  end
`endif

  assign w_accept     = (r_state == S_IDLE) && (w_grant0 || w_grant1);
  assign w_rsp_hs     = r_owner ? i_rsp1_ready : i_rsp0_ready;
  assign o_req0_ready = (r_state == S_IDLE) && w_grant0;
  assign o_req1_ready = (r_state == S_IDLE) && w_grant1;

  assign o_rsp0_valid = r_rsp0_valid;
  assign o_rsp1_valid = r_rsp1_valid;
  assign o_rsp_data   = r_rsp_data;
  assign o_rsp_ovf    = r_rsp_ovf;
  assign o_alu_a      = r_alu_a;
  assign o_alu_b      = r_alu_b;
  assign o_alu_shamt  = r_alu_shamt;
  assign o_alu_op     = r_alu_op;

  // Sequencer: operand latch, wait counter, result capture and response.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_owner      <= 1'b0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_ovf    <= 1'b0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_shamt  <= '0;
      r_alu_op     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            // ALU inputs come straight from these registers, so they stay
            // put outside EXEC until the next accepted request.
            r_owner     <= w_grant1;
            r_alu_op    <= w_grant1 ? i_req1_op    : i_req0_op;
            r_alu_a     <= w_grant1 ? i_req1_a     : i_req0_a;
            r_alu_b     <= w_grant1 ? i_req1_b     : i_req0_b;
            r_alu_shamt <= w_grant1 ? i_req1_shamt : i_req0_shamt;
            r_cnt       <= '0;
            r_state     <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (r_cnt == LAT_CNT) begin
            r_rsp_data   <= i_alu_o;
            r_rsp_ovf    <= i_alu_ovf;
            r_rsp0_valid <= !r_owner;
            r_rsp1_valid <= r_owner;
            r_state      <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_RESP: begin
          if (w_rsp_hs) begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_cnt        <= '0;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
